// File: rtl/fpc_pkg.sv
// Shared constants and helpers for the FPC DMA read-request path.
package fpc_pkg;

    localparam int FPC_TAG_W      = 8;
    localparam int FPC_WORD_BYTES = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Tag layout is {channel, tag_low}, zero-extended to FPC_TAG_W.
    function automatic logic [FPC_TAG_W-1:0] fpc_pack_tag(input int ch, input int tag_low,
                                                          input int tag_low_w);
        return FPC_TAG_W'((ch << tag_low_w) | tag_low);
    endfunction

endpackage

// File: rtl/fpc_req_counter.sv
// One channel's request address/count; load when idle, step once per grant.
// FPC_RR_ABORT_EN adds i_abort, which clears the count ahead of load and step.
module fpc_req_counter
    import fpc_pkg::*;
#(
    parameter int AW = 55,
    parameter int CW = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic [CW-1:0] i_count,
    input  logic          i_step,
`ifdef FPC_RR_ABORT_EN
    input  logic          i_abort,
`endif
    output logic          o_idle,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] r_word_addr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_addr <= '0;
            r_cnt       <= '0;
        end
`ifdef FPC_RR_ABORT_EN
        else if (i_abort) begin
            r_cnt <= '0;
        end
`endif
        else if (i_load) begin
            r_word_addr <= i_addr;
            r_cnt       <= i_count;
        end else if (i_step) begin
            r_word_addr <= r_word_addr + AW'(1);
            r_cnt       <= r_cnt - CW'(1);
        end
    end

    assign o_idle = (r_cnt == '0);
    assign o_addr = r_word_addr;

endmodule

// File: rtl/fpc_rr_mux_n.sv
// N-channel read-request splitter with work-conserving round-robin merge; r_valid->rrm_valid 2 cycles.
// One request per clock; rrm_ready low freezes the output and all grants. FPC_RR_ABORT_EN adds r_abort.
module fpc_rr_mux_n
    import fpc_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int ADDR_W    = 61,
    parameter int CNT_W     = 19,
    parameter int REQ_SHIFT = 6,
    parameter int TAG_LOW_W = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NCH-1:0]              r_valid,
    input  logic [ADDR_W-1:0]           r_addr,
    input  logic [CNT_W-1:0]            r_count,
    output logic [NCH-1:0]              r_ready,
`ifdef FPC_RR_ABORT_EN
    input  logic [NCH-1:0]              r_abort,
`endif
    input  logic [NCH-1:0]              rr_valid,
    input  logic [NCH*TAG_LOW_W-1:0]    rr_tag_low,
    output logic [NCH-1:0]              rr_ready,
    output logic                        rrm_valid,
    output logic [ADDR_W-REQ_SHIFT-1:0] rrm_addr,
    output logic [FPC_TAG_W-1:0]        rrm_tag,
    input  logic                        rrm_ready
);

    localparam int RA_W  = ADDR_W - REQ_SHIFT;
    localparam int RC_W  = CNT_W - REQ_SHIFT;
    localparam int PTR_W = (NCH > 1) ? clog2(NCH) : 1;

    logic [NCH-1:0]       w_idle;
    logic [NCH-1:0]       w_elig;
    logic [NCH-1:0]       w_step;
    logic [RA_W-1:0]      w_addr [NCH];
    logic                 w_slot_free;
    logic                 w_grant;
    logic [PTR_W-1:0]     w_win;
    logic [TAG_LOW_W-1:0] w_tag_low;
    logic                 w_unused;

    logic [PTR_W-1:0]     r_ptr;
    logic                 r_rrm_valid;
    logic [RA_W-1:0]      r_rrm_addr;
    logic [FPC_TAG_W-1:0] r_rrm_tag;

    // Sub-request low bits of address and length are dropped by design.
    assign w_unused = ^{r_addr[REQ_SHIFT-1:0], r_count[REQ_SHIFT-1:0]};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fpc_req_counter #(
            .AW (RA_W),
            .CW (RC_W)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .i_load  (r_valid[i] & w_idle[i]),
            .i_addr  (r_addr[ADDR_W-1:REQ_SHIFT]),
            .i_count (r_count[CNT_W-1:REQ_SHIFT]),
            .i_step  (w_step[i]),
`ifdef FPC_RR_ABORT_EN
            .i_abort (r_abort[i]),
`endif
            .o_idle  (w_idle[i]),
            .o_addr  (w_addr[i])
        );
    end

    function automatic int wrap_ch(input int v);
        return (v >= NCH) ? v - NCH : v;
    endfunction

    assign w_elig      = ~w_idle & rr_valid;
    assign w_slot_free = ~r_rrm_valid | rrm_ready;
    assign w_grant     = w_slot_free & (|w_elig);

    // Scan farthest-first so the nearest eligible channel after r_ptr wins.
    always_comb begin
        w_win = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (w_elig[wrap_ch(int'(r_ptr) + k)]) w_win = PTR_W'(wrap_ch(int'(r_ptr) + k));
        end
    end

    always_comb begin
        w_step = '0;
        if (w_grant) w_step[w_win] = 1'b1;
    end

    assign w_tag_low = rr_tag_low[int'(w_win)*TAG_LOW_W +: TAG_LOW_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= PTR_W'(NCH - 1);
            r_rrm_valid <= 1'b0;
            r_rrm_addr  <= '0;
            r_rrm_tag   <= '0;
        end else if (w_slot_free) begin
            r_rrm_valid <= w_grant;
            if (w_grant) begin
                r_rrm_addr <= w_addr[w_win];
                r_rrm_tag  <= fpc_pack_tag(int'(w_win), int'(w_tag_low), TAG_LOW_W);
                r_ptr      <= w_win;
            end
        end
    end

    assign r_ready   = w_idle;
    assign rr_ready  = w_step;
    assign rrm_valid = r_rrm_valid;
    assign rrm_addr  = r_rrm_addr;
    assign rrm_tag   = r_rrm_tag;

endmodule

// File: tb/tb_fpc_rr_mux_n.sv
// Directed plus randomized bench for fpc_rr_mux_n against a per-channel work-list model.
module tb_fpc_rr_mux_n;

    localparam int NCH = 4;
    localparam int TLW = 3;

    logic              clock;
    logic              reset;
    logic [NCH-1:0]    r_valid;
    logic [60:0]       r_addr;
    logic [18:0]       r_count;
    logic [NCH-1:0]    r_ready;
    logic [NCH-1:0]    rr_valid;
    logic [NCH*TLW-1:0] rr_tag_low;
    logic [NCH-1:0]    rr_ready;
    logic              rrm_valid;
    logic [54:0]       rrm_addr;
    logic [7:0]        rrm_tag;
    logic              rrm_ready;
`ifdef FPC_RR_ABORT_EN
    logic [NCH-1:0]    r_abort;
`endif

    fpc_rr_mux_n dut (
        .clock      (clock),
        .reset      (reset),
        .r_valid    (r_valid),
        .r_addr     (r_addr),
        .r_count    (r_count),
        .r_ready    (r_ready),
`ifdef FPC_RR_ABORT_EN
        .r_abort    (r_abort),
`endif
        .rr_valid   (rr_valid),
        .rr_tag_low (rr_tag_low),
        .rr_ready   (rr_ready),
        .rrm_valid  (rrm_valid),
        .rrm_addr   (rrm_addr),
        .rrm_tag    (rrm_tag),
        .rrm_ready  (rrm_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_pulse = 0;

    // Reference state: remaining requests and next request address per channel.
    int          m_rem  [NCH];
    logic [54:0] m_next [NCH];
    int          m_last;
    logic        m_ov;
    logic [54:0] m_oa;
    logic [7:0]  m_ot;

    typedef struct {
        logic [54:0] addr;
        logic [7:0]  tag;
        int          cyc;
    } cap_t;
    cap_t cap[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int w;
        logic free;
        logic [NCH-1:0] exp_rrr;
        logic [NCH-1:0] exp_idle;
        #1;
        free = !m_ov || rrm_ready;
        w = -1;
        for (int k = 1; k <= NCH; k++) begin
            int c = (m_last + k) % NCH;
            if (w < 0 && m_rem[c] > 0 && rr_valid[c]) w = c;
        end
        exp_rrr = '0;
        if (free && w >= 0) exp_rrr[w] = 1'b1;
        for (int c = 0; c < NCH; c++) exp_idle[c] = (m_rem[c] == 0);
        chk("rrm_valid", 64'(rrm_valid), 64'(m_ov));
        if (m_ov) begin
            chk("rrm_addr", 64'(rrm_addr), 64'(m_oa));
            chk("rrm_tag", 64'(rrm_tag), 64'(m_ot));
        end
        chk("rr_ready", 64'(rr_ready), 64'(exp_rrr));
        chk("r_ready", 64'(r_ready), 64'(exp_idle));
        if (rrm_valid && rrm_ready) cap.push_back('{rrm_addr, rrm_tag, cyc});
        n_pulse += $countones(rr_ready);
        @(posedge clock);
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_rem[c]  = 0;
                m_next[c] = '0;
            end
            m_last = NCH - 1;
            m_ov = 1'b0;
            m_oa = '0;
            m_ot = '0;
        end else begin
            if (free) begin
                if (w >= 0) begin
                    m_ov = 1'b1;
                    m_oa = m_next[w];
                    m_ot = 8'((w << TLW) | int'(rr_tag_low[w*TLW +: TLW]));
                    m_next[w] = m_next[w] + 55'd1;
                    m_rem[w]  = m_rem[w] - 1;
                    m_last = w;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (r_valid[c] && exp_idle[c]) begin
                    m_rem[c]  = int'(r_count >> 6);
                    m_next[c] = r_addr[60:6];
                end
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cap.delete();
        n_pulse = 0;
    endtask

    initial begin
        int t0;
        reset      = 1'b1;
        r_valid    = '0;
        r_addr     = '0;
        r_count    = '0;
        rr_valid   = '1;
        rr_tag_low = {3'd5, 3'd2, 3'd3, 3'd4};
        rrm_ready  = 1'b1;
`ifdef FPC_RR_ABORT_EN
        r_abort    = '0;
`endif
        for (int c = 0; c < NCH; c++) begin
            m_rem[c]  = 0;
            m_next[c] = '0;
        end
        m_last = NCH - 1;
        m_ov = 1'b0;
        m_oa = '0;
        m_ot = '0;
        @(negedge clock);
        cycle();
        do_reset();

        // Reset state
        #1;
        chk("rst_rrm_valid", 64'(rrm_valid), 64'd0);
        chk("rst_rrm_addr", 64'(rrm_addr), 64'd0);
        chk("rst_rrm_tag", 64'(rrm_tag), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'hF);

        // 1: single channel, four back-to-back requests
        r_valid = 4'b0001; r_addr = 61'h1000; r_count = 19'd256;
        t0 = cyc;
        cycle();
        r_valid = '0;
        for (int i = 0; i < 7; i++) cycle();
        chk("t1_count", 64'(cap.size()), 64'd4);
        if (cap.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", 64'(cap[i].addr), 64'h40 + 64'(i));
                chk("t1_tag", 64'(cap[i].tag), 64'h04);
                chk("t1_cyc", 64'(cap[i].cyc), 64'(t0 + 2 + i));
            end
        end
        chk("t1_r_ready", 64'(r_ready), 64'hF);

        // 2: all four channels loaded together
        do_reset();
        r_valid = 4'b1111; r_addr = 61'h2000; r_count = 19'd128;
        cycle();
        r_valid = '0;
        for (int i = 0; i < 12; i++) cycle();
        chk("t2_count", 64'(cap.size()), 64'd8);
        chk("t2_pulses", 64'(n_pulse), 64'd8);
        if (cap.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_chan", 64'(cap[i].tag[4:3]), 64'(i % 4));
                chk("t2_addr", 64'(cap[i].addr), 64'h80 + 64'(i / 4));
            end
        end

        // 3: idle channels skipped without a bubble
        do_reset();
        r_valid = 4'b1010; r_addr = 61'h0; r_count = 19'd64;
        t0 = cyc;
        cycle();
        r_valid = '0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t3_count", 64'(cap.size()), 64'd2);
        if (cap.size() == 2) begin
            chk("t3_ch1", 64'(cap[0].tag[4:3]), 64'd1);
            chk("t3_ch1_cyc", 64'(cap[0].cyc), 64'(t0 + 2));
            chk("t3_ch3", 64'(cap[1].tag[4:3]), 64'd3);
            chk("t3_ch3_cyc", 64'(cap[1].cyc), 64'(t0 + 3));
        end

        // 4: downstream stall holds output and blocks grants
        do_reset();
        r_valid = 4'b0001; r_addr = 61'h3000; r_count = 19'd512;
        cycle();
        r_valid = '0;
        cycle();
        rrm_ready = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_addr", 64'(rrm_addr), 64'hC0);
            chk("t4_hold_valid", 64'(rrm_valid), 64'd1);
            chk("t4_r_ready", 64'(r_ready[0]), 64'd0);
            cycle();
        end
        chk("t4_no_pulse", 64'(n_pulse), 64'd0);
        rrm_ready = 1'b1;
        #1;
        chk("t4_release", 64'(rr_ready), 64'b0001);
        for (int i = 0; i < 10; i++) cycle();
        chk("t4_count", 64'(cap.size()), 64'd8);

        // 5: channel without a free tag is skipped until it gets one
        do_reset();
        rr_valid = 4'b1011;
        r_valid = 4'b1111; r_addr = 61'h4000; r_count = 19'd64;
        cycle();
        r_valid = '0;
        for (int i = 0; i < 5; i++) cycle();
        rr_valid = 4'b1111;
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_count", 64'(cap.size()), 64'd4);
        if (cap.size() == 4) begin
            chk("t5_ord0", 64'(cap[0].tag[4:3]), 64'd0);
            chk("t5_ord1", 64'(cap[1].tag[4:3]), 64'd1);
            chk("t5_ord2", 64'(cap[2].tag[4:3]), 64'd3);
            chk("t5_ord3", 64'(cap[3].tag[4:3]), 64'd2);
        end

        // 6: reset mid-transfer
        do_reset();
        r_valid = 4'b0001; r_addr = 61'h5000; r_count = 19'd320;
        cycle();
        r_valid = '0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cap.delete();
        #1;
        chk("t6_valid", 64'(rrm_valid), 64'd0);
        chk("t6_r_ready", 64'(r_ready), 64'hF);
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_quiet", 64'(cap.size()), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r_valid    = 4'($urandom) & 4'($urandom) & 4'($urandom);
            r_count    = 19'($urandom_range(0, 64 * 5 + 63));
            r_addr     = 61'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                r_addr = '1;
                r_addr[8:0] = 9'($urandom);
            end
            rr_valid   = ~(4'($urandom) & 4'($urandom));
            rr_tag_low = 12'($urandom);
            rrm_ready  = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpc_rr_mux_n.md
Name: fpc_rr_mux_n

Overview:
Parametrised N-channel read-request multiplexer for the FPC (FIFO-to-PC) DMA path.
- Each channel holds one outstanding transfer: base word address plus count in 8-byte words.
- The transfer is broken into fixed-size read requests of 2^REQ_SHIFT words each.
- A work-conserving round-robin arbiter merges all channels onto a single read-request stream toward the TLP generator.
- Each request carries an 8-bit tag encoding {channel, per-channel tag_low}.
- Improvements over the fixed 4-state predecessor: skips idle channels in zero cycles, sustains one request per clock, generic channel count.

Parameters:
NCH, 4, number of channels (1..16)
ADDR_W, 61, r_addr width in 8-byte words
CNT_W, 19, r_count width in 8-byte words
REQ_SHIFT, 6, log2 words per read request (64 words = 512 B)
TAG_LOW_W, 3, per-channel tag_low width; require clog2(NCH)+TAG_LOW_W <= 8

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
r_valid  in  NCH  per-channel load strobe for r_addr/r_count
r_addr  in  ADDR_W  shared transfer base address, words
r_count  in  CNT_W  shared transfer length, words
r_ready  out  NCH  channel i idle (remaining request count == 0)
rr_valid  in  NCH  channel i has a free tag
rr_tag_low  in  NCH*TAG_LOW_W  packed tag_low per channel; channel i in bits [i*TAG_LOW_W +: TAG_LOW_W]
rr_ready  out  NCH  one-cycle pulse: tag of channel i consumed
rrm_valid  out  1  output request valid
rrm_addr  out  ADDR_W-REQ_SHIFT  request address in 2^REQ_SHIFT-word units
rrm_tag  out  8  zero-extended {channel, tag_low}
rrm_ready  in  1  downstream accepts the request

Behaviour:
- Reset, synchronous:
  - all channel counts = 0, addrs = 0, so r_ready = all ones
  - rrm_valid = 0, rrm_addr = 0, rrm_tag = 0
  - RR pointer = NCH-1, so channel 0 has first priority
- Load: on r_valid[i] & r_ready[i]:
  - addr_i <= r_addr >> REQ_SHIFT
  - cnt_i <= r_count >> REQ_SHIFT (low bits truncated)
- r_valid[i] while r_ready[i] = 0 is ignored.
- Several channels loaded in the same cycle each take the same r_addr/r_count.
- Eligible[i] = (cnt_i != 0) & rr_valid[i].
- Output slot free = ~rrm_valid | rrm_ready.
- Grant, when the slot is free and any channel is eligible:
  - winner = first eligible channel searching from ptr+1 upward, modulo NCH
  - same cycle: rr_ready[winner] = 1
  - next edge: rrm_addr <= addr_w; rrm_tag <= {w, tag_low_w}; rrm_valid <= 1; addr_w += 1; cnt_w -= 1; ptr <= w
- Slot free and no channel eligible: rrm_valid <= 0.
- rrm_valid = 1 and rrm_ready = 0: rrm_valid, rrm_addr and rrm_tag hold stable; no grant; rr_ready = 0.
- Throughput: one request per cycle with rrm_ready held high.
- Latency: r_valid at cycle 0 -> rrm_valid at cycle 2.
- rr_ready is combinational from the registered counts, rr_valid, ptr and rrm_ready. It has no combinational path from r_valid.
- Load and grant cannot collide on one channel (load requires cnt = 0, grant requires cnt != 0).
- Address increment wraps modulo 2^(ADDR_W-REQ_SHIFT).
- r_ready[i] rises on the edge where the last request is granted, not when it is accepted downstream.
- Reset mid-transfer: pending counts are discarded; a held rrm_valid is dropped.

Optional Feature:
- Macro FPC_RR_ABORT_EN adds input r_abort[NCH].
- With it defined: r_abort[i] clears cnt_i on the next edge, and r_ready[i] = 1 on the following cycle.
  - If channel i is granted in the same cycle as the abort, that grant still completes. rrm_valid is not retracted.
  - r_abort has priority over r_valid for the same channel.
- Without it: the port does not exist, and a transfer runs to completion or reset.

Decomposition:
- Package fpc_pkg holds:
  - constants FPC_TAG_W = 8, FPC_WORD_BYTES = 8
  - function clog2
  - tag-packing function {ch, tag_low}
- Sub-module fpc_req_counter, one per channel, generated: address/count registers with load, step and optional abort; outputs idle and addr.
- Arbiter and output register live in the top.

Test Plan:
1. Reset, then load ch0 with r_addr = 0x1000, r_count = 256, all rr_valid = 1, rrm_ready = 1 -> four requests with rrm_addr 0x40..0x43 and tag {0, tag_low}, back-to-back from cycle 2; r_ready[0] high again after the 4th grant.
2. Load ch0..3 with count 128 each, same cycle -> grant order 0,1,2,3,0,1,2,3; exactly one rr_ready pulse per grant; eight requests total.
3. Ch1 and ch3 loaded with count 64, ch0 and ch2 idle -> ch1 at cycle 2 and ch3 at cycle 3; idle channels are skipped with no bubble.
4. Hold rrm_ready = 0 for 5 cycles with rrm_valid = 1 -> output stable, rr_ready = 0, counts unchanged; release -> next grant in the same cycle.
5. rr_valid[2] = 0 while ch2 has work -> ch2 is skipped and no rr_ready[2] pulse; raise rr_valid[2] -> ch2 is granted at its next RR turn.
6. Assert reset with ch0 at count 3 remaining and rrm_valid high -> next cycle rrm_valid = 0, r_ready = all ones, no further requests.
